// File: rtl/undistort_pkg.sv
// undistort_pkg
//   Shared definitions for the undistort pipeline's bilinear interpolator:
//   default image/pixel geometry, the interpolator state encoding and a
//   helper that turns a fractional bit count into the weight scale S.
package undistort_pkg;

    localparam int PIX_W     = 8;
    localparam int FRAC_BITS = 4;
    localparam int COLS      = 320;
    localparam int ROWS      = 240;
    localparam int ADDR_W    = 17;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TOP   = 3'd1,
        ST_BOT   = 3'd2,
        ST_VERT  = 3'd3,
        ST_WRITE = 3'd4
    } interp_state_t;

    // Weight scale S = 2^frac_bits; the two lerp weights always sum to S.
    function automatic int frac_scale(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    localparam int S = frac_scale(FRAC_BITS);

endpackage

// File: rtl/interp_lerp.sv
// interp_lerp
//   Combinational weighted blend y = a*(S-f) + b*f with S = 2^FRAC_BITS.
//   The result is W+FRAC_BITS bits wide, which holds the full unsigned sum
//   because the weights add up to S.
// Ports:
//   a, b  in   W bits          operands
//   f     in   FRAC_BITS bits  fractional weight of b
//   y     out  W+FRAC_BITS     blended result
module interp_lerp #(
    parameter int W         = 12,
    parameter int FRAC_BITS = 4
) (
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    input  logic [FRAC_BITS-1:0]   f,
    output logic [W+FRAC_BITS-1:0] y
);
    import undistort_pkg::*;

    localparam int OW = W + FRAC_BITS;

    logic [OW-1:0] a_ext;
    logic [OW-1:0] b_ext;
    logic [OW-1:0] wa;
    logic [OW-1:0] wb;

    always_comb begin
        a_ext = OW'(a);
        b_ext = OW'(b);
        wb    = OW'(f);
        wa    = OW'(frac_scale(FRAC_BITS)) - wb;
        y     = a_ext * wa + b_ext * wb;
    end

endmodule

// File: rtl/bilinear_interpolator.sv
// bilinear_interpolator
//   Computes one bilinear-weighted output pixel per start pulse and writes
//   it to the output frame BRAM at v*COLS+u. Sequence is fixed at
//   IDLE -> TOP -> BOT -> VERT -> WRITE, so wr_en/done land in the 4th cycle
//   after the accepting clock edge regardless of data.
//   Optional build macro INTERP_ROUND_EN: round half up in the vertical pass
//   instead of truncating.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   start               single-cycle start pulse, honoured only in IDLE
//   u, v                output column / row
//   p00 p01 p10 p11     source neighbours (TL, TR, BL, BR)
//   fx, fy              fractional source offsets
//   oob                 source coordinate outside the image
//   wr_en/wr_addr/wr_data  output BRAM write port
//   busy                high in any non-IDLE state
//   done                one-cycle completion pulse
module bilinear_interpolator #(
    parameter int PIX_W      = undistort_pkg::PIX_W,
    parameter int FRAC_BITS  = undistort_pkg::FRAC_BITS,
    parameter int COLS       = undistort_pkg::COLS,
    parameter int ROWS       = undistort_pkg::ROWS,
    parameter int ADDR_W     = undistort_pkg::ADDR_W,
    parameter int BORDER_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8:0]           u,
    input  logic [8:0]           v,
    input  logic [PIX_W-1:0]     p00,
    input  logic [PIX_W-1:0]     p01,
    input  logic [PIX_W-1:0]     p10,
    input  logic [PIX_W-1:0]     p11,
    input  logic [FRAC_BITS-1:0] fx,
    input  logic [FRAC_BITS-1:0] fy,
    input  logic                 oob,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [PIX_W-1:0]     wr_data,
    output logic                 busy,
    output logic                 done
);
    import undistort_pkg::*;

    localparam int MID_W = PIX_W + FRAC_BITS;
    localparam int ACC_W = PIX_W + 2 * FRAC_BITS;
    localparam logic [31:0] COLS_U = 32'(COLS);
    localparam logic [31:0] ROWS_U = 32'(ROWS);

    interp_state_t state;
    interp_state_t state_nxt;

    logic [8:0]           u_q;
    logic [8:0]           v_q;
    logic [PIX_W-1:0]     p00_q;
    logic [PIX_W-1:0]     p01_q;
    logic [PIX_W-1:0]     p10_q;
    logic [PIX_W-1:0]     p11_q;
    logic [FRAC_BITS-1:0] fx_q;
    logic [FRAC_BITS-1:0] fy_q;
    logic                 oob_q;

    logic [MID_W-1:0]     top_q;
    logic [MID_W-1:0]     bot_q;

    logic [MID_W-1:0]     lerp_a;
    logic [MID_W-1:0]     lerp_b;
    logic [FRAC_BITS-1:0] lerp_f;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_adj;
    logic [PIX_W-1:0]     pix_d;
    logic [ADDR_W-1:0]    addr_d;
    logic                 in_frame;

    // Single blend unit shared by the two horizontal passes and the vertical
    // pass; the operand mux below picks its inputs from the current state.
    interp_lerp #(
        .W         (MID_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_lerp (
        .a (lerp_a),
        .b (lerp_b),
        .f (lerp_f),
        .y (acc)
    );

    always_comb begin
        lerp_a = '0;
        lerp_b = '0;
        lerp_f = '0;
        case (state)
            ST_TOP: begin
                lerp_a = MID_W'(p00_q);
                lerp_b = MID_W'(p01_q);
                lerp_f = fx_q;
            end
            ST_BOT: begin
                lerp_a = MID_W'(p10_q);
                lerp_b = MID_W'(p11_q);
                lerp_f = fx_q;
            end
            ST_VERT: begin
                lerp_a = top_q;
                lerp_b = bot_q;
                lerp_f = fy_q;
            end
            default: ;
        endcase
    end

    // Weights sum to S^2, so even with the rounding offset the shifted
    // value stays within PIX_W bits.
    always_comb begin
`ifdef INTERP_ROUND_EN
        acc_adj = acc + ACC_W'(1 << (2 * FRAC_BITS - 1));
`else
        acc_adj = acc;
`endif
        if (oob_q)
            pix_d = PIX_W'(BORDER_VAL);
        else
            pix_d = PIX_W'(acc_adj >> (2 * FRAC_BITS));
    end

    always_comb begin
        addr_d   = ADDR_W'(v_q) * ADDR_W'(COLS) + ADDR_W'(u_q);
        in_frame = (32'(u_q) < COLS_U) && (32'(v_q) < ROWS_U);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_TOP;
            ST_TOP:   state_nxt = ST_BOT;
            ST_BOT:   state_nxt = ST_VERT;
            ST_VERT:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_WRITE);
        wr_en = (state == ST_WRITE) && in_frame;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_q     <= '0;
            v_q     <= '0;
            p00_q   <= '0;
            p01_q   <= '0;
            p10_q   <= '0;
            p11_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            oob_q   <= 1'b0;
            top_q   <= '0;
            bot_q   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        u_q   <= u;
                        v_q   <= v;
                        p00_q <= p00;
                        p01_q <= p01;
                        p10_q <= p10;
                        p11_q <= p11;
                        fx_q  <= fx;
                        fy_q  <= fy;
                        oob_q <= oob;
                    end
                end
                ST_TOP:  top_q <= MID_W'(acc);
                ST_BOT:  bot_q <= MID_W'(acc);
                ST_VERT: begin
                    wr_data <= pix_d;
                    wr_addr <= addr_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bilinear_interpolator.sv
// tb_bilinear_interpolator
//   Directed, table-driven bench for bilinear_interpolator with default
//   geometry (8-bit pixels, 4 fractional bits, 320x240, BORDER_VAL=0).
//   Expected pixel values are hand-computed; rounding cases select their
//   expectation on INTERP_ROUND_EN.
module tb_bilinear_interpolator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  u;
    logic [8:0]  v;
    logic [7:0]  p00, p01, p10, p11;
    logic [3:0]  fx, fy;
    logic        oob;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    bilinear_interpolator #(
        .PIX_W      (8),
        .FRAC_BITS  (4),
        .COLS       (320),
        .ROWS       (240),
        .ADDR_W     (17),
        .BORDER_VAL (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .u       (u),
        .v       (v),
        .p00     (p00),
        .p01     (p01),
        .p10     (p10),
        .p11     (p11),
        .fx      (fx),
        .fy      (fy),
        .oob     (oob),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p00, p01, p10, p11;
        logic [3:0] fx, fy;
        logic [8:0] u, v;
        logic       oob;
        logic       exp_wr;
        int         exp_addr;
        int         exp_data;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int fxi, input int fyi, input int ui, input int vi,
                                input bit o, input bit w, input int ea, input int ed);
        vec_t t;
        t.p00 = 8'(a);  t.p01 = 8'(b);  t.p10 = 8'(c);  t.p11 = 8'(d);
        t.fx  = 4'(fxi); t.fy = 4'(fyi);
        t.u   = 9'(ui);  t.v  = 9'(vi);
        t.oob = o; t.exp_wr = w; t.exp_addr = ea; t.exp_data = ed;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t t);
        p00 = t.p00; p01 = t.p01; p10 = t.p10; p11 = t.p11;
        fx = t.fx; fy = t.fy; u = t.u; v = t.v; oob = t.oob;
    endtask

    // Launch one operation and observe 8 cycles after the accepting edge.
    // With repulse set, start is re-asserted with junk inputs through TOP,
    // BOT, VERT and WRITE; none of that may affect the result.
    task automatic run_op(input vec_t t, input int id, input bit repulse);
        int done_cnt = 0;
        int done_cyc = -1;
        int wr_cnt   = 0;
        int busy_err = 0;
        int cap_addr = 0;
        int cap_data = 0;
        @(negedge clk);
        drive_vec(t);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (busy !== (cyc <= 4)) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                cap_addr = int'(wr_addr);
                cap_data = int'(wr_data);
            end
            if (wr_en === 1'b1) wr_cnt++;
            if (repulse && cyc <= 4) begin
                start = 1'b1;
                p00 = 8'($urandom); p01 = 8'($urandom);
                p10 = 8'($urandom); p11 = 8'($urandom);
                fx = 4'($urandom); fy = 4'($urandom);
                u = 9'($urandom_range(0, 300)); v = 9'($urandom_range(0, 200));
                oob = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("vec%0d done_count", id), done_cnt, 1);
        check($sformatf("vec%0d done_latency", id), done_cyc, 4);
        check($sformatf("vec%0d wr_en_count", id), wr_cnt, int'(t.exp_wr));
        check($sformatf("vec%0d busy_pattern_errs", id), busy_err, 0);
        if (t.exp_wr) begin
            check($sformatf("vec%0d wr_addr", id), cap_addr, t.exp_addr);
            check($sformatf("vec%0d wr_data", id), cap_data, t.exp_data);
            check($sformatf("vec%0d wr_addr_hold", id), int'(wr_addr), t.exp_addr);
            check($sformatf("vec%0d wr_data_hold", id), int'(wr_data), t.exp_data);
        end
    endtask

    initial begin
        int rd_half;
        int rd_mix;
        int bad;
`ifdef INTERP_ROUND_EN
        rd_half = 128;
        rd_mix  = 28;
`else
        rd_half = 127;
        rd_mix  = 27;
`endif
        //             p00  p01  p10  p11 fx fy   u    v  oob wr  addr   data
        vecs[0] = mk(100, 100, 100, 100,  5, 11,   0,   0, 0, 1,     0, 100);
        vecs[1] = mk(  0, 255,   0,   0,  8,  0,   1,   0, 0, 1,     1, rd_half);
        vecs[2] = mk(  0,   0,   0, 255, 15, 15, 319, 239, 0, 1, 76799, 224);
        vecs[3] = mk(200, 200, 200, 200,  7,  9,   3,   4, 1, 1,  1283, 0);
        vecs[4] = mk( 10,  20,  30,  40,  4, 12,   5,   2, 0, 1,   645, rd_mix);
        vecs[5] = mk(255,   0,   0,   0,  0,  0,  10,   1, 0, 1,   330, 255);
        vecs[6] = mk(100, 100, 100, 100,  3,  3, 320,   0, 0, 0,     0, 0);
        vecs[7] = mk(100, 100, 100, 100,  3,  3,   0, 240, 0, 0,     0, 0);

        rst = 1'b0;
        start = 1'b0;
        drive_vec(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        check("reset wr_en", int'(wr_en), 0);
        check("reset done", int'(done), 0);
        check("reset busy", int'(busy), 0);
        check("reset wr_addr", int'(wr_addr), 0);
        check("reset wr_data", int'(wr_data), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i], i, 1'b0);

        // Re-pulsed start with changing inputs mid-operation.
        run_op(vecs[4], 14, 1'b1);

        // Reset asserted while in BOT: no write, no done, registers cleared.
        @(negedge clk);
        drive_vec(vecs[2]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midreset in BOT busy", int'(busy), 1);
        rst = 1'b0;
        #2;
        check("midreset busy", int'(busy), 0);
        check("midreset wr_data", int'(wr_data), 0);
        check("midreset wr_addr", int'(wr_addr), 0);
        bad = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 2) begin
                @(negedge clk);
                rst = 1'b1;
            end
            @(posedge clk);
            #1;
            if (wr_en !== 1'b0 || done !== 1'b0) bad++;
        end
        check("midreset no write/done", bad, 0);
        run_op(vecs[2], 22, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
